aes_core_sched: RTL and testbench

Request scheduler that shares one `aes_cipher_top` encryption core between `NREQ` independent requesters. It accepts key/plaintext pairs over per-requester valid/ready handshakes and grants the core round-robin. It then sequences the core's `ld`/`done` protocol and returns each ciphertext on that requester's response handshake. It sits between the client blocks and the single AES core instance, and is the only driver of the core's `ld`, `key` and `text_in`.

---
 rtl/aes_sched_pkg.sv | 15 +
 rtl/aes_rr_pick.sv | 24 ++
 rtl/aes_core_sched.sv | 179 +++++++++++++++++
 tb/tb_aes_core_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core request scheduler.
// Holds the FSM state enum, block width and default watchdog limit.
package aes_sched_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } sched_state_e;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above
// ptr (wrapping). Ports: valid, ptr in; idx (winner), any out.
module aes_rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan downward so the candidate closest to ptr is written last.
  always_comb begin
    idx = '0;
    any = |valid;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES core between NREQ requesters, round-robin, with
// valid/ready request and response handshakes and core ld/done
// sequencing. Ports: req_*, rsp_*, busy, core_*. Optional watchdog
// enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_core_sched
  import aes_sched_pkg::*;
#(
  parameter  int NREQ           = 2,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_DEF,
  localparam int GW             = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*AES_BLK_W-1:0] req_key,
  input  logic [NREQ*AES_BLK_W-1:0] req_text,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [AES_BLK_W-1:0]      rsp_text,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      core_ld,
  output logic [AES_BLK_W-1:0]      core_key,
  output logic [AES_BLK_W-1:0]      core_text_in,
  input  logic [AES_BLK_W-1:0]      core_text_out,
  input  logic                      core_done
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("aes_core_sched: bad NREQ/TIMEOUT_CYCLES");
  end

  sched_state_e         state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic                 armed_q, armed_d;
  logic                 ld_q, ld_d;
  logic                 busy_q, busy_d;
  logic [NREQ-1:0]      rval_q, rval_d;
  logic [AES_BLK_W-1:0] rtxt_q, rtxt_d;
  logic [AES_BLK_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] pt_q, pt_d;

  logic [GW-1:0] win;
  logic          any;

  aes_rr_pick #(.N(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .idx   (win),
    .any   (any)
  );

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rerr_q, rerr_d;
  logic          tmo;
  assign tmo = (int'(cnt_q) >= TIMEOUT_CYCLES - 1);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    armed_d   = armed_q;
    ld_d      = 1'b0;
    rval_d    = rval_q;
    rtxt_d    = rtxt_q;
    key_d     = key_q;
    pt_d      = pt_q;
    req_ready = '0;
`ifdef AES_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    rerr_d    = rerr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          req_ready[win] = 1'b1;
          key_d   = req_key[int'(win)*AES_BLK_W +: AES_BLK_W];
          pt_d    = req_text[int'(win)*AES_BLK_W +: AES_BLK_W];
          gnt_d   = win;
          ld_d    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        armed_d = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done is only trusted once a full WAIT cycle has elapsed
        armed_d = 1'b1;
        if (armed_q && core_done) begin
          rtxt_d        = core_text_out;
          rval_d        = '0;
          rval_d[gnt_q] = 1'b1;
          state_d       = S_RESP;
`ifdef AES_SCHED_TIMEOUT_EN
          rerr_d        = 1'b0;
        end else if (tmo) begin
          rtxt_d        = '0;
          rerr_d        = 1'b1;
          rval_d        = '0;
          rval_d[gnt_q] = 1'b1;
          state_d       = S_RESP;
`endif
        end
`ifdef AES_SCHED_TIMEOUT_EN
        if (int'(cnt_q) < TIMEOUT_CYCLES) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready[gnt_q]) begin
          rval_d  = '0;
          ptr_d   = (int'(gnt_q) == NREQ - 1) ? '0
                                                : gnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      armed_q <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      rval_q  <= '0;
      rtxt_q  <= '0;
      key_q   <= '0;
      pt_q    <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      rerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      armed_q <= armed_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      rval_q  <= rval_d;
      rtxt_q  <= rtxt_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
`ifdef AES_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      rerr_q  <= rerr_d;
`endif
    end
  end

  assign rsp_valid    = rval_q;
  assign rsp_text     = rtxt_q;
  assign busy         = busy_q;
  assign core_ld      = ld_q;
  assign core_key     = key_q;
  assign core_text_in = pt_q;
`ifdef AES_SCHED_TIMEOUT_EN
  assign rsp_err      = rerr_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with a behavioural AES core model.
// Timeout case runs when AES_SCHED_TIMEOUT_EN is defined.
module tb_aes_core_sched;

  localparam int LAT = 4;
  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CB = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] KC = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] PC = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] KD = 128'h1234567890abcdef1234567890abcdef;
  localparam logic [127:0] PD = 128'hcafebabedeadbeef0123456789abcdef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [255:0] req_key = '0;
  logic [255:0] req_text = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = '0;
  logic [127:0] rsp_text;
  logic         rsp_err;
  logic         busy;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic [127:0] core_text_out;
  logic         core_done;

  int total = 0;
  int bad   = 0;

  aes_core_sched #(.NREQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_key       (req_key),
    .req_text      (req_text),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_text      (rsp_text),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text_in  (core_text_in),
    .core_text_out (core_text_out),
    .core_done     (core_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_enc(
    input logic [127:0] k, input logic [127:0] t);
    if (k == KA && t == PA) return CA;
    if (k == KB && t == PB) return CB;
    return k ^ t;
  endfunction

  // Core model: done is a level held until the next ld. In stale mode the
  // old done/result stays up through the first cycle after ld.
  bit           stale_mode = 0;
  bit           never_mode = 0;
  logic         m_run;
  int           m_cnt;
  int           m_stale;
  logic [127:0] m_k, m_t;
  int           ld_cnt = 0;

  always @(posedge clk) begin
    if (core_ld) ld_cnt <= ld_cnt + 1;
    if (rst) begin
      m_run <= 0; m_cnt <= 0; m_stale <= 0;
      core_done <= 0; core_text_out <= '0;
      m_k <= '0; m_t <= '0;
    end else if (core_ld) begin
      m_run <= 1; m_cnt <= LAT;
      m_k <= core_key; m_t <= core_text_in;
      m_stale <= stale_mode ? 1 : 0;
      if (!stale_mode) core_done <= 0;
    end else if (m_stale > 0) begin
      m_stale <= 0;
      core_done <= 0;
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run <= 0;
        core_done <= !never_mode;
        core_text_out <= ref_enc(m_k, m_t);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit saw);
    cyc = 0;
    saw = 0;
    while (rsp_valid == '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) saw = 1;
    end
    if (rsp_valid == '0) chk("rsp_wait", 0, 1);
  endtask

  task automatic set_req(input int i,
                         input logic [127:0] k,
                         input logic [127:0] t);
    req_key[i*128 +: 128]  = k;
    req_text[i*128 +: 128] = t;
    req_valid[i] = 1'b1;
  endtask

  task automatic ack(input int i);
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    chk("rsp_clr", rsp_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int  cyc;
  bit  saw;
  bit  flag;
  int  base;
  logic [127:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rval", rsp_valid, 0);
    chk("rst_ld", core_ld, 0);
    chk("rst_key", core_key, 0);
    chk("rst_pt", core_text_in, 0);
    chk("rst_rtxt", rsp_text, 0);
    chk("rst_err", rsp_err, 0);

    // single request from requester 0
    base = ld_cnt;
    set_req(0, KA, PA);
    #1 chk("s_rdy", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    chk("s_ld", core_ld, 1);
    chk("s_key", core_key, KA);
    chk("s_pt", core_text_in, PA);
    chk("s_busy", busy, 1);
    wait_rsp(cyc, saw);
    chk("s_rval", rsp_valid, 2'b01);
    chk("s_txt", rsp_text, CA);
    chk("s_err", rsp_err, 0);
    chk("s_ldn", ld_cnt - base, 1);
    ack(0);

    // simultaneous requests after reset
    do_reset();
    set_req(0, KA, PA);
    set_req(1, KB, PB);
    #1 chk("m_rdy", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("m_key0", core_key, KA);
    wait_rsp(cyc, saw);
    chk("m_rdy1_early", saw, 0);
    chk("m_rval0", rsp_valid, 2'b01);
    chk("m_txt0", rsp_text, CA);
    chk("m_rdy_resp", req_ready, 0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    chk("m_rdy1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    chk("m_key1", core_key, KB);
    wait_rsp(cyc, saw);
    chk("m_rval1", rsp_valid, 2'b10);
    chk("m_txt1", rsp_text, CB);
    ack(1);

    // response backpressure, requester 1 waiting meanwhile
    set_req(0, KC, PC);
    set_req(1, KB, PB);
    #1 chk("b_rdy", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(cyc, saw);
    chk("b_txt", rsp_text, KC ^ PC);
    held = rsp_text;
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != 2'b01 || rsp_text != held ||
          req_ready != '0 || core_ld) flag = 1;
    end
    chk("b_hold", flag, 0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    chk("b_rdy1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(cyc, saw);
    chk("b_txt1", rsp_text, CB);
    ack(1);

    // stale done held across LOAD and first WAIT cycle
    stale_mode = 1;
    set_req(0, KD, PD);
    @(negedge clk);
    req_valid = '0;
    chk("st_ld", core_ld, 1);
    wait_rsp(cyc, saw);
    stale_mode = 0;
    chk("st_txt", rsp_text, KD ^ PD);
    chk("st_lat", cyc > LAT, 1);
    ack(0);

    // reset two cycles after core_ld; ptr is 1 before the reset
    set_req(1, KA, PA);
    #1 chk("r_rdy", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0;
    chk("r_ld", core_ld, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_busy", busy, 0);
    chk("r_rval", rsp_valid, 0);
    chk("r_key", core_key, 0);
    chk("r_pt", core_text_in, 0);
    chk("r_rtxt", rsp_text, 0);
    chk("r_ld0", core_ld, 0);
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) flag = 1;
    end
    chk("r_norsp", flag, 0);
    set_req(0, KA, PA);
    set_req(1, KB, PB);
    #1 chk("r_ptr0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(cyc, saw);
    chk("r_txt", rsp_text, CA);
    ack(0);

`ifdef AES_SCHED_TIMEOUT_EN
    // core never completes; watchdog answers with an error
    never_mode = 1;
    set_req(1, KB, PB);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(cyc, saw);
    chk("t_rval", rsp_valid, 2'b10);
    chk("t_err", rsp_err, 1);
    chk("t_txt", rsp_text, 0);
    ack(1);
    never_mode = 0;
    set_req(0, KA, PA);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(cyc, saw);
    chk("t2_err", rsp_err, 0);
    chk("t2_txt", rsp_text, CA);
    ack(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
